// File: rtl/escalonador_pkg.sv
// Shared definitions for the BCD transmit scheduler: FSM state encoding and BCD byte width.
package escalonador_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    DISPARA = 3'd2,
    ESPERA  = 3'd3,
    CONCLUI = 3'd4
  } estado_t;

  localparam int LARG_BCD = 8;

endpackage

// File: rtl/arbitro_round_robin.sv
// Combinational rotate-priority encoder: first set request after i_ultimo, wrapping modulo N_REQ.
module arbitro_round_robin
  import escalonador_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [W-1:0]     i_ultimo,
  output logic [W-1:0]     o_vencedor
);

  // Scan from farthest to nearest so the nearest set request wins.
  always_comb begin
    int         w_idx;
    logic [W-1:0] w_idx_w;
    w_idx      = 0;
    w_idx_w    = '0;
    o_vencedor = i_ultimo;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx   = (int'(i_ultimo) + k) % N_REQ;
      w_idx_w = W'(w_idx);
      if (i_req[w_idx_w]) o_vencedor = w_idx_w;
    end
  end

endmodule

// File: rtl/escalonador_transmissao_bcd.sv
// Round-robin scheduler sharing one BCD serial transmitter among N_REQ requesters.
// Optional wait-for-pronto timeout enabled by defining ESCALONADOR_TIMEOUT_EN.
//
// state   | meaning
// OCIOSO  | idle, arbitrating among raised requests
// CARREGA | latch winner index and its BCD byte
// DISPARA | one-cycle start pulse to the transmitter
// ESPERA  | waiting for transmitter pronto (or timeout)
// CONCLUI | one-cycle ack to the served requester
module escalonador_transmissao_bcd
  import escalonador_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CICLOS = 50000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [LARG_BCD*N_REQ-1:0] i_bcd_in,
  output logic [N_REQ-1:0]          o_ack,
  output logic [$clog2(N_REQ)-1:0]  o_concedido,
  output logic                      o_ocupado,
  output logic [LARG_BCD-1:0]       o_tx_bcd,
  output logic                      o_tx_start,
  input  logic                      i_tx_pronto,
  output logic                      o_erro
);

  localparam int W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CICLOS < 2) begin : g_param_invalido
    $error("escalonador_transmissao_bcd: N_REQ must be 2..8 and TIMEOUT_CICLOS >= 2");
  end

  estado_t             r_estado, w_prox_estado;
  logic [W-1:0]        r_ultimo, r_vencedor, r_concedido, w_vencedor;
  logic [LARG_BCD-1:0] r_tx_bcd, w_bcd_sel;
  logic                w_timeout;

  arbitro_round_robin #(.N_REQ(N_REQ), .W(W)) u_arbitro (
    .i_req      (i_req),
    .i_ultimo   (r_ultimo),
    .o_vencedor (w_vencedor)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_estado <= OCIOSO;
    else         r_estado <= w_prox_estado;
  end

  always_comb begin
    w_prox_estado = r_estado;
    case (r_estado)
      OCIOSO:  if (|i_req) w_prox_estado = CARREGA;
      CARREGA: w_prox_estado = DISPARA;
      DISPARA: w_prox_estado = ESPERA;
      ESPERA:  if (i_tx_pronto || w_timeout) w_prox_estado = CONCLUI;
      CONCLUI: w_prox_estado = OCIOSO;
      default: w_prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    o_ack      = '0;
    o_tx_start = (r_estado == DISPARA);
    o_ocupado  = (r_estado != OCIOSO);
    if (r_estado == CONCLUI) o_ack[r_concedido] = 1'b1;
  end

  always_comb begin
    w_bcd_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_vencedor == W'(i)) w_bcd_sel = i_bcd_in[LARG_BCD*i +: LARG_BCD];
    end
  end

  // Winner is frozen in OCIOSO so request changes during CARREGA cannot redirect the grant.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_ultimo    <= W'(N_REQ - 1);
      r_vencedor  <= '0;
      r_concedido <= '0;
      r_tx_bcd    <= '0;
    end else begin
      if (r_estado == OCIOSO) r_vencedor <= w_vencedor;
      if (r_estado == CARREGA) begin
        r_concedido <= r_vencedor;
        r_ultimo    <= r_vencedor;
        r_tx_bcd    <= w_bcd_sel;
      end
    end
  end

  assign o_concedido = r_concedido;
  assign o_tx_bcd    = r_tx_bcd;

`ifdef ESCALONADOR_TIMEOUT_EN
  localparam int W_CONT = $clog2(TIMEOUT_CICLOS + 1);

  logic [W_CONT-1:0] r_cont;
  logic              r_erro;

  // Counter holds k-1 in the k-th cycle after tx_start, so ack lands TIMEOUT_CICLOS cycles after it.
  assign w_timeout = (r_estado == ESPERA) && (r_cont == W_CONT'(TIMEOUT_CICLOS - 2));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cont <= '0;
      r_erro <= 1'b0;
    end else begin
      if (r_estado == DISPARA)     r_cont <= '0;
      else if (r_estado == ESPERA) r_cont <= r_cont + W_CONT'(1);
      if (w_timeout && !i_tx_pronto) r_erro <= 1'b1;
    end
  end

  assign o_erro = r_erro;
`else
  assign w_timeout = 1'b0;
  assign o_erro    = 1'b0;
`endif

endmodule
